data_mem_responder: RTL and testbench

//  Multi-cycle data-memory responder: the slave end of the CPU load/store port.

---
 rtl/data_mem_responder.sv | 178 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle word data memory: slave end of the CPU load/store port with WAIT_CYCLES wait states.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LP_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic            r_busy;
  logic            r_ack;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_go;
  logic            w_acc_we;
  logic [AW-1:0]   w_acc_idx;
  logic [31:0]     w_acc_wdata;
  logic            w_unused_addr;

  // Bits above the word index only select aliases of the same word.
  assign w_unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_mis;
  logic r_err;
  logic w_acc_mis;
`endif

  // Decide whether the memory access happens on this edge.
  always_comb begin
    w_go = 1'b0;
    case (r_state)
      S_IDLE:  w_go = req_i && (WAIT_CYCLES == 0);
      S_WAIT:  w_go = (r_cnt == LP_LAST);
      default: w_go = 1'b0;
    endcase
  end

  // With zero wait states the access uses the request inputs directly.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_acc_we    = we_i;
      w_acc_idx   = addr_i[AW+1:2];
      w_acc_wdata = wdata_i;
    end else begin
      w_acc_we    = r_we;
      w_acc_idx   = r_idx;
      w_acc_wdata = r_wdata;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Misalignment flag follows the same source selection as the access.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_acc_mis = (addr_i[1:0] != 2'b00);
    end else begin
      w_acc_mis = r_mis;
    end
  end
`endif

  // Request FSM, memory array and registered response outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
`endif
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
          r_err <= 1'b0;
`endif
          if (req_i) begin
            r_we    <= we_i;
            r_idx   <= addr_i[AW+1:2];
            r_wdata <= wdata_i;
`ifdef DMEM_ALIGN_CHECK_EN
            r_mis   <= (addr_i[1:0] != 2'b00);
`endif
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 4'd1;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ack   <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
          r_err   <= 1'b0;
`endif
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ack   <= 1'b0;
        end
      endcase

      // The access edge overrides the state bookkeeping above.
      if (w_go) begin
        r_state <= S_RESP;
        r_busy  <= 1'b1;
        r_ack   <= 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
        if (w_acc_mis) begin
          r_err   <= 1'b1;
          r_rdata <= 32'd0;
        end else if (w_acc_we) begin
          r_mem[w_acc_idx] <= w_acc_wdata;
        end else begin
          r_rdata <= r_mem[w_acc_idx];
        end
`else
        if (w_acc_we) begin
          r_mem[w_acc_idx] <= w_acc_wdata;
        end else begin
          r_rdata <= r_mem[w_acc_idx];
        end
`endif
      end
    end
  end

  assign busy_o  = r_busy;
  assign ack_o   = r_ack;
  assign rdata_o = r_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
  assign err_o   = r_err;
`else
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (DEPTH_WORDS=128, WAIT_CYCLES=2).
module tb_data_mem_responder;

  localparam int DEPTH = 128;
  localparam int WC    = 2;
  localparam int LAT   = WC + 1;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        err_o;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m [DEPTH];
  logic [31:0] last_rd;
  int          total = 0;
  int          bad   = 0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i] = 32'd0;
    last_rd = 32'd0;
    q.delete();
  endtask

  // Compute the expected response of an accepted request and queue it.
  task automatic push_exp(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    logic [6:0] idx;
    logic mis;
    idx = addr[8:2];
`ifdef DMEM_ALIGN_CHECK_EN
    mis = (addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    if (mis) begin
      last_rd = 32'd0;
      e.rd = 32'd0;
      e.err = 1'b1;
    end else if (we) begin
      m[idx] = wd;
      e.rd = last_rd;
      e.err = 1'b0;
    end else begin
      last_rd = m[idx];
      e.rd = m[idx];
      e.err = 1'b0;
    end
    q.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected ack, scoreboard empty", name);
    end else begin
      e = q.pop_front();
      if ({rdata_o, err_o} !== {e.rd, e.err}) begin
        bad++;
        $display("FAIL %s: got rdata=%h err=%b, expected rdata=%h err=%b",
                 name, rdata_o, err_o, e.rd, e.err);
      end
    end
  endtask

  // Single request from idle; checks busy/ack timing over the full transaction.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input string name);
    logic exp_busy, exp_ack;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
    push_exp(we, addr, wd);
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0;
    for (int i = 1; i <= LAT + 1; i++) begin
      if (i > 1) @(negedge clk);
      exp_busy = (i <= LAT);
      exp_ack  = (i == LAT);
      total++;
      if ({busy_o, ack_o} !== {exp_busy, exp_ack}) begin
        bad++;
        $display("FAIL %s timing cycle %0d: busy=%b ack=%b, expected busy=%b ack=%b",
                 name, i, busy_o, ack_o, exp_busy, exp_ack);
      end
      if (ack_o === 1'b1) pop_check(name);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({busy_o, ack_o, rdata_o, err_o} !== {1'b0, 1'b0, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: busy=%b ack=%b rdata=%h err=%b, expected all 0",
               busy_o, ack_o, rdata_o, err_o);
    end
    rst_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_timing();
    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "write_0x10");
  endtask

  task automatic test_read_hold();
    do_req(1'b0, 32'h0000_0010, 32'd0, "read_0x10");
    do_req(1'b1, 32'h0000_0040, 32'h0000_0055, "write_hold_rdata");
    do_req(1'b0, 32'h0000_0040, 32'd0, "read_0x40");
  endtask

  task automatic test_wrap();
    do_req(1'b1, 32'h0000_0204, 32'h0000_1234, "write_wrap_0x204");
    do_req(1'b0, 32'h0000_0004, 32'd0, "read_wrap_0x004");
    do_req(1'b0, 32'hFFFF_FE10, 32'd0, "read_alias_high");
  endtask

  // req_i held high; new address each cycle shows which requests were taken.
  task automatic test_back_to_back();
    int acks = 0;
    logic exp_ack;
    for (int t = 0; t < 16; t++) begin
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'(4 * t); wdata_i = 32'd0;
      if ((t % (WC + 2)) == 0) push_exp(1'b0, 32'(4 * t), 32'd0);
      @(negedge clk);
      exp_ack = (((t + 1) % (WC + 2)) == LAT);
      total++;
      if (ack_o !== exp_ack) begin
        bad++;
        $display("FAIL b2b_ack cycle %0d: ack=%b expected %b", t + 1, ack_o, exp_ack);
      end
      if (ack_o === 1'b1) begin
        acks++;
        pop_check("b2b_data");
      end
    end
    req_i = 1'b0; addr_i = 32'd0;
    total++;
    if (acks !== 4) begin
      bad++;
      $display("FAIL b2b_count: got %0d acks, expected 4", acks);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    do_req(1'b0, 32'h0000_0010, 32'd0, "read_before_reset");
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0020; wdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    req_i = 1'b0; we_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    total++;
    if ({busy_o, ack_o, rdata_o, err_o} !== {1'b0, 1'b0, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL midflight_reset: busy=%b ack=%b rdata=%h err=%b, expected all 0",
               busy_o, ack_o, rdata_o, err_o);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    do_req(1'b0, 32'h0000_0020, 32'd0, "read_0x20_after_reset");
    do_req(1'b0, 32'h0000_0010, 32'd0, "read_0x10_after_reset");
  endtask

  task automatic test_align();
    do_req(1'b1, 32'h0000_0022, 32'h0000_0077, "write_0x22");
    do_req(1'b0, 32'h0000_0020, 32'd0, "read_0x20_after_0x22");
  endtask

  initial begin
    test_reset();
    test_write_timing();
    test_read_hold();
    test_wrap();
    test_back_to_back();
    test_reset_midflight();
    test_align();
    total++;
    if (q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
